// File: rtl/neuron_mac_piped_if.sv
// Handshake and data bundle between the pair source, the neuron MAC and the sigmoid stage.
// Carries the input pair stream with its ready/valid handshake, the bias, and the result word with its valid pulse and clamp flag.
// master = pair source / result consumer; slave = the MAC itself.
interface neuron_mac_piped_if #(
    parameter int BITSIZE = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [BITSIZE-1:0] x_in;
    logic [BITSIZE-1:0] w_in;
    logic [BITSIZE-1:0] bias;
    logic [BITSIZE-1:0] data_out;
    logic               out_valid;
    logic               sat;

    modport master (
        output in_valid, x_in, w_in, bias,
        input  in_ready, data_out, out_valid, sat
    );

    modport slave (
        input  in_valid, x_in, w_in, bias,
        output in_ready, data_out, out_valid, sat
    );
endinterface

// File: rtl/neuron_mac_piped.sv
// Pipelined dot-product + bias unit producing a saturated sign-magnitude Q4.11 pre-activation.
// Latency: 3 edges from the last accepted pair to the out_valid pulse; one neuron per N_INPUTS+2 cycles.
// Backpressure: in_ready is a pure state decode, low for the FLUSH and DONE cycles only.
module neuron_mac_piped #(
    parameter int BITSIZE  = 16,
    parameter int FRAC     = 11,
    parameter int ACC_W    = 32,
    parameter int N_INPUTS = 8
) (
    input  logic               clk,
    input  logic               reset,
    neuron_mac_piped_if.slave  bus
);
    localparam int MAG_W  = BITSIZE - 1;
    localparam int PROD_W = 2 * MAG_W;
    localparam int PMAG_W = PROD_W - FRAC;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    // Largest magnitude representable in the output word, as a signed sum-width constant.
    localparam logic signed [ACC_W:0] MAX_POS = {{(ACC_W + 1 - MAG_W){1'b0}}, {MAG_W{1'b1}}};
    localparam logic signed [ACC_W:0] MIN_NEG = -MAX_POS;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  prod_reg;
    logic                     prod_vld;

    logic                     accept;
    logic [PROD_W-1:0]        prod_full;
    logic [PMAG_W-1:0]        prod_mag;
    logic                     prod_sign;
    logic signed [ACC_W-1:0]  prod_next;
    logic signed [ACC_W-1:0]  bias_twos;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W:0]    neg_sum;
    logic [BITSIZE-1:0]       enc;
    logic                     enc_sat;

    assign bus.in_ready = (state == ST_ACC);
    assign accept       = bus.in_valid && bus.in_ready;

    // Magnitude product, truncated toward zero; a zero magnitude never carries a sign.
    assign prod_full = {{MAG_W{1'b0}}, bus.x_in[MAG_W-1:0]} * {{MAG_W{1'b0}}, bus.w_in[MAG_W-1:0]};
    assign prod_mag  = prod_full[PROD_W-1:FRAC];
    assign prod_sign = (bus.x_in[BITSIZE-1] ^ bus.w_in[BITSIZE-1]) && (prod_mag != '0);
    assign prod_next = prod_sign ? -$signed(ACC_W'(prod_mag)) : $signed(ACC_W'(prod_mag));

    // Bias converted to two's complement; sum is one bit wider so the add itself cannot wrap.
    assign bias_twos = bus.bias[BITSIZE-1] ? -$signed(ACC_W'(bus.bias[MAG_W-1:0]))
                                           :  $signed(ACC_W'(bus.bias[MAG_W-1:0]));
    assign sum       = {acc[ACC_W-1], acc} + {bias_twos[ACC_W-1], bias_twos};

    // Clamp the sum to the sign-magnitude range and encode it; zero always encodes as +0.
    always_comb begin
        enc     = '0;
        enc_sat = 1'b0;
        neg_sum = -sum;
        if (sum > MAX_POS) begin
            enc     = {1'b0, {MAG_W{1'b1}}};
            enc_sat = 1'b1;
        end else if (sum < MIN_NEG) begin
            enc     = {1'b1, {MAG_W{1'b1}}};
            enc_sat = 1'b1;
        end else if (sum < 0) begin
            enc = {1'b1, neg_sum[MAG_W-1:0]};
        end else begin
            enc = {1'b0, sum[MAG_W-1:0]};
        end
    end

    // Two-stage datapath: register the signed product on accept, then fold it into acc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_reg <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
        end else begin
            prod_vld <= accept;
            if (accept) begin
                prod_reg <= prod_next;
            end
            if (state == ST_DONE) begin
                acc <= '0;
            end else if (prod_vld) begin
                acc <= acc + prod_reg;
            end
        end
    end

    // Sequencer: count pairs, drain the product pipe, then register the saturated result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_ACC;
            cnt           <= '0;
            bus.data_out  <= '0;
            bus.sat       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                ST_ACC: begin
                    if (accept) begin
                        if (cnt == CNT_W'(N_INPUTS - 1)) begin
                            cnt   <= '0;
                            state <= ST_FLUSH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    bus.data_out  <= enc;
                    bus.sat       <= enc_sat;
                    bus.out_valid <= 1'b1;
                    state         <= ST_ACC;
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_piped.sv
// Directed bench for neuron_mac_piped: table of uniform-pair neurons plus hand sequences
// for cancellation, bubbles with a held pair across FLUSH/DONE, and mid-neuron reset.
module tb_neuron_mac_piped;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    neuron_mac_piped_if #(.BITSIZE(16)) bus();

    neuron_mac_piped #(
        .BITSIZE(16), .FRAC(11), .ACC_W(32), .N_INPUTS(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] d;
        logic        s;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the edge that accepted the pair.
    task automatic send_pair(input logic [15:0] x, input logic [15:0] w, input bit bubble);
        int  guard = 0;
        bit  done  = 0;
        while (!done) begin
            bus.x_in     = x;
            bus.w_in     = w;
            bus.in_valid = bubble ? ($urandom_range(0, 2) != 0) : 1'b1;
            done         = bus.in_valid && bus.in_ready;
            @(posedge clk);
            @(negedge clk);
            guard++;
            if (!done && guard > 50) begin
                chk("accept_timeout", 0, 1);
                done = 1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Called at the negedge right after the last accept (N0). Optionally holds a pair valid
    // through FLUSH/DONE; that pair is then consumed at E3 as pair 1 of the next neuron.
    task automatic check_result(input string name, input logic [15:0] exp_d, input logic exp_s,
                                input bit hold, input logic [15:0] hx, input logic [15:0] hw);
        if (hold) begin
            bus.x_in     = hx;
            bus.w_in     = hw;
            bus.in_valid = 1'b1;
        end
        chk({name, "_rdy_flush"}, int'(bus.in_ready), 0);
        chk({name, "_vld_flush"}, int'(bus.out_valid), 0);
        @(posedge clk); @(negedge clk);
        chk({name, "_rdy_done"}, int'(bus.in_ready), 0);
        chk({name, "_vld_done"}, int'(bus.out_valid), 0);
        @(posedge clk); @(negedge clk);
        chk({name, "_vld"},  int'(bus.out_valid), 1);
        chk({name, "_data"}, int'(bus.data_out), int'(exp_d));
        chk({name, "_sat"},  int'(bus.sat), int'(exp_s));
        chk({name, "_rdy_back"}, int'(bus.in_ready), 1);
        @(posedge clk); @(negedge clk);
        bus.in_valid = 1'b0;
        chk({name, "_vld_drop"}, int'(bus.out_valid), 0);
        chk({name, "_data_hold"}, int'(bus.data_out), int'(exp_d));
    endtask

    initial begin
        vecs[0]  = '{16'h0800, 16'h0400, 16'h0000, 16'h2000, 1'b0, "pos_4p0"};
        vecs[1]  = '{16'h1000, 16'h8C00, 16'h0000, 16'hFFFF, 1'b1, "neg_sat"};
        vecs[2]  = '{16'h0800, 16'h0400, 16'h0000, 16'h2000, 1'b0, "sat_clear"};
        vecs[3]  = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 1'b0, "trunc_zero"};
        vecs[4]  = '{16'h8000, 16'h8800, 16'h0400, 16'h0400, 1'b0, "neg_zero"};
        vecs[5]  = '{16'h0800, 16'h8400, 16'h0000, 16'hA000, 1'b0, "neg_4p0"};
        vecs[6]  = '{16'h0800, 16'h0800, 16'h3FFF, 16'h7FFF, 1'b0, "max_exact"};
        vecs[7]  = '{16'h0800, 16'h0800, 16'h4000, 16'h7FFF, 1'b1, "pos_over"};
        vecs[8]  = '{16'h0800, 16'h8800, 16'hBFFF, 16'hFFFF, 1'b0, "min_exact"};
        vecs[9]  = '{16'h0800, 16'h8800, 16'hC000, 16'hFFFF, 1'b1, "neg_over"};
        vecs[10] = '{16'h7FFF, 16'h0800, 16'h0000, 16'h7FFF, 1'b1, "big_pos"};

        bus.in_valid = 1'b0;
        bus.x_in     = '0;
        bus.w_in     = '0;
        bus.bias     = '0;

        repeat (3) @(negedge clk);
        chk("rst_data", int'(bus.data_out), 0);
        chk("rst_sat",  int'(bus.sat), 0);
        chk("rst_vld",  int'(bus.out_valid), 0);
        chk("rst_rdy",  int'(bus.in_ready), 1);
        reset = 1'b0;
        @(negedge clk);

        // Uniform-pair neurons, back to back.
        for (int i = 0; i < 11; i++) begin
            bus.bias = vecs[i].b;
            for (int p = 0; p < 8; p++) send_pair(vecs[i].x, vecs[i].w, 1'b0);
            check_result(vecs[i].name, vecs[i].d, vecs[i].s, 1'b0, 16'h0, 16'h0);
        end

        // Cancellation to -0.25, then to an exact zero.
        bus.bias = 16'h8200;
        for (int p = 0; p < 4; p++) send_pair(16'h0800, 16'h0800, 1'b0);
        for (int p = 0; p < 4; p++) send_pair(16'h0800, 16'h8800, 1'b0);
        check_result("cancel", 16'h8200, 1'b0, 1'b0, 16'h0, 16'h0);
        bus.bias = 16'h8000;
        for (int p = 0; p < 4; p++) send_pair(16'h0800, 16'h0800, 1'b0);
        for (int p = 0; p < 4; p++) send_pair(16'h0800, 16'h8800, 1'b0);
        check_result("cancel_zero", 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);

        // Bubbles, and a (1.0, 1.0) pair held valid through FLUSH/DONE.
        bus.bias = 16'h0000;
        for (int p = 0; p < 8; p++) send_pair(16'h0800, 16'h0400, 1'b1);
        check_result("bubble", 16'h2000, 1'b0, 1'b1, 16'h0800, 16'h0800);
        // Held pair was pair 1: 1.0 + 7 * 0.5 = 4.5.
        for (int p = 0; p < 7; p++) send_pair(16'h0800, 16'h0400, 1'b1);
        check_result("held_pair", 16'h2400, 1'b0, 1'b0, 16'h0, 16'h0);

        // Reset after 5 accepted pairs discards the partial neuron.
        for (int p = 0; p < 5; p++) send_pair(16'h0800, 16'h0400, 1'b0);
        reset = 1'b1;
        #2;
        chk("mid_rst_data", int'(bus.data_out), 0);
        chk("mid_rst_sat",  int'(bus.sat), 0);
        chk("mid_rst_vld",  int'(bus.out_valid), 0);
        chk("mid_rst_rdy",  int'(bus.in_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 8; p++) send_pair(16'h0800, 16'h0400, 1'b0);
        check_result("post_rst", 16'h2000, 1'b0, 1'b0, 16'h0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
